hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central scheduler for the 5-stage pipeline. It drives stall/flush/bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Produces registered forwarding selects aligned to the EX stage.
- Sequences multi-cycle data-memory waits, with a timeout flag and a stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 16: number of consecutive wait cycles on one dmem access after which mem_timeout sets.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active-high (1 = reset); name kept per codebase port naming
- id_rs1  in  5  ID-stage source 1 index
- id_rs2  in  5  ID-stage source 2 index
- id_rs1_re  in  1  ID instruction reads rs1
- id_rs2_re  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage destination
- ex_rf_we  in  1  EX-stage writes RF
- ex_is_load  in  1  EX-stage instruction is a load
- mem_rd  in  5  MEM-stage destination
- mem_rf_we  in  1  MEM-stage writes RF
- ex_br_taken  in  1  EX-stage branch/jump redirect
- dmem_req  in  1  MEM-stage access to data memory
- dmem_ack  in  1  data memory completes access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  clear IF/ID
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  clear ID/EX (bubble)
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_bubble  out  1  force MEM/WB rf_we input to 0
- fwd_a  out  2  EX operand A select, registered: 00 RF, 01 from MEM, 10 from WB
- fwd_b  out  2  same for operand B
- stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating at all-ones
- mem_timeout  out  1  sticky timeout flag

Behaviour:
- A match is hit(rs, re, rd, we) = re & we & (rd != 0) & (rs == rd). x0 never matches.
- freeze = dmem_req & ~dmem_ack. This is combinational. It sets pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble to 1. All flushes are 0 while freeze is 1.
- Load-use: lu = ex_is_load & (hit(id_rs1,id_rs1_re,ex_rd,ex_rf_we) | hit(id_rs2,...)).
  - When active it sets pc_stall=1, if_id_stall=1 and id_ex_flush=1 for that cycle.
  - Exactly one bubble is inserted per load.
- Branch: ex_br_taken sets if_id_flush=1 and id_ex_flush=1.
- Priority: freeze > branch > load-use.
  - A branch while frozen is ignored; it is seen again after release because EX is held.
  - A branch suppresses lu; no stall is raised.
- FSM with states RUN and WAIT:
  - RUN -> WAIT when freeze=1.
  - WAIT stays in WAIT while freeze=1. WAIT -> RUN on the cycle dmem_ack=1, or when dmem_req drops.
  - The release cycle itself is not frozen.
  - A new freeze in the cycle after release re-enters WAIT and clears wait_cnt.
- wait_cnt:
  - Cleared in RUN; increments each WAIT cycle.
  - When wait_cnt reaches MEM_TIMEOUT-1 and freeze is still 1, mem_timeout <= 1. It is sticky until reset.
  - The pipeline stays frozen after a timeout; there is no forced release.
- Forwarding registers (fwd_a, fwd_b, updated each clock):
  - Frozen: hold their value.
  - Else if id_ex_flush=1: load 00.
  - Else: fwd_a <= 01 if hit(id_rs1,id_rs1_re,ex_rd,ex_rf_we) & ~ex_is_load; else 10 if hit(id_rs1,id_rs1_re,mem_rd,mem_rf_we); else 00. fwd_b uses rs2 the same way.
  - Nearer stage wins. After the load-use bubble the load sits in MEM, so the consumer receives 10 (WB).
- stall_cnt: +1 on each clock where pc_stall=1; saturates at 2^CNT_W-1.
- Reset (rst_n=1 at clk edge):
  - State=RUN, wait_cnt=0, fwd_a=fwd_b=00, stall_cnt=0, mem_timeout=0.
  - While rst_n=1 all combinational stall/flush/bubble outputs are forced to 0.
  - Reset mid-WAIT returns to RUN immediately.
- Latency: stall, flush and bubble outputs are combinational, same cycle. Forwarding selects take effect 1 cycle after the ID-stage compare.

Test Plan:
- Reset: rst_n=1 for 2 cycles with dmem_req=1 -> all outputs 0, state RUN, stall_cnt=0.
- Load-use: ex_is_load=1, ex_rd=5, ex_rf_we=1; id_rs1=5, id_rs1_re=1 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1. Next cycle mem_rd=5 -> following cycle fwd_a=10. stall_cnt=1.
- ALU forwarding: ex_rd=3, ex_rf_we=1, not a load, and mem_rd=3, mem_rf_we=1; id_rs2=3, id_rs2_re=1 -> next cycle fwd_b=01, no stall. Repeat with rd=0 -> fwd_b=00.
- Branch vs load-use: ex_br_taken=1 together with a load-use match -> if_id_flush=id_ex_flush=1, pc_stall=0; next cycle fwd_a=fwd_b=00.
- Memory wait: dmem_req=1, dmem_ack=0 for 4 cycles, then ack -> freeze outputs high for exactly 4 cycles, fwd held, stall_cnt+=4, mem_timeout stays 0. A concurrent ex_br_taken produces no flush until release.
- Timeout and sticky: MEM_TIMEOUT=4, dmem_req=1 without ack for 6 cycles -> mem_timeout rises when wait_cnt=3, stays 1 after ack, clears only on rst_n=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: stall/flush/bubble control, EX-aligned forwarding
// selects and data-memory wait sequencing with timeout and stall statistics.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_re,
   input  logic             id_rs2_re,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rf_we,
   input  logic             ex_is_load,
   input  logic [4:0]       mem_rd,
   input  logic             mem_rf_we,
   input  logic             ex_br_taken,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             mem_timeout
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {ST_RUN, ST_WAIT} state_t;

   function automatic logic hit(input logic [4:0] rs, input logic re,
                                input logic [4:0] rd, input logic we);
      return re & we & (rd != 5'd0) & (rs == rd);
   endfunction

   state_t           state_reg;
   logic [WC_W-1:0]  wait_cnt_reg;
   logic             mem_timeout_reg;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic       freeze, br_act, lu_act;
   logic [4:0] src_rs [2];
   logic       src_re [2];
   logic       hit_ex [2];
   logic       hit_mem [2];
   logic [1:0] fwd_reg [2];
   logic [1:0] fwd_next [2];

   assign src_rs[0] = id_rs1;
   assign src_rs[1] = id_rs2;
   assign src_re[0] = id_rs1_re;
   assign src_re[1] = id_rs2_re;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign hit_ex[gi]  = hit(src_rs[gi], src_re[gi], ex_rd, ex_rf_we);
         assign hit_mem[gi] = hit(src_rs[gi], src_re[gi], mem_rd, mem_rf_we);

         // Nearer stage wins; a load in EX cannot forward yet
         always_comb begin
            fwd_next[gi] = 2'b00;
            if (hit_ex[gi] && !ex_is_load)
               fwd_next[gi] = 2'b01;
            else if (hit_mem[gi])
               fwd_next[gi] = 2'b10;
         end

         always_ff @(posedge clk) begin
            if (rst_n)
               fwd_reg[gi] <= 2'b00;
            else if (freeze)
               fwd_reg[gi] <= fwd_reg[gi];
            else if (id_ex_flush)
               fwd_reg[gi] <= 2'b00;
            else
               fwd_reg[gi] <= fwd_next[gi];
         end
      end
   endgenerate

   // Priority: memory freeze, then branch redirect, then load-use
   always_comb begin
      freeze = 1'b0;
      br_act = 1'b0;
      lu_act = 1'b0;
      if (!rst_n) begin
         freeze = dmem_req & ~dmem_ack;
         br_act = ex_br_taken & ~freeze;
         lu_act = ex_is_load & (hit_ex[0] | hit_ex[1]) & ~freeze & ~br_act;
      end
   end

   assign pc_stall      = freeze | lu_act;
   assign if_id_stall   = freeze | lu_act;
   assign if_id_flush   = br_act;
   assign id_ex_stall   = freeze;
   assign id_ex_flush   = br_act | lu_act;
   assign ex_mem_stall  = freeze;
   assign mem_wb_bubble = freeze;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_reg       <= ST_RUN;
         wait_cnt_reg    <= '0;
         mem_timeout_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_RUN: begin
               wait_cnt_reg <= '0;
               if (freeze)
                  state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               if (freeze) begin
                  // Counter parks at the threshold; the flag is sticky anyway
                  if (wait_cnt_reg == WC_W'(MEM_TIMEOUT - 1))
                     mem_timeout_reg <= 1'b1;
                  else
                     wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end else begin
                  state_reg    <= ST_RUN;
                  wait_cnt_reg <= '0;
               end
            end
            default: state_reg <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n)
         stall_cnt_reg <= '0;
      else if (pc_stall && stall_cnt_reg != {CNT_W{1'b1}})
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
   end

   assign fwd_a       = fwd_reg[0];
   assign fwd_b       = fwd_reg[1];
   assign stall_cnt   = stall_cnt_reg;
   assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;

   localparam int MT = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd;
   logic          id_rs1_re, id_rs2_re, ex_rf_we, ex_is_load, mem_rf_we;
   logic          ex_br_taken, dmem_req, dmem_ack;
   logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic          ex_mem_stall, mem_wb_bubble, mem_timeout;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
      .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .ex_br_taken(ex_br_taken),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
      .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall_cnt(stall_cnt), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   // Reference model state: expected registered outputs and the length of
   // the current run of consecutive frozen cycles
   int m_fa, m_fb, m_scnt, m_to, m_run;
   bit e_frz, e_pc, e_idf;

   typedef struct {
      int rs1, re1, rs2, re2, ex_rd, ex_we, ex_ld, mem_rd, mem_we, br, req, ack;
      int e_pc, e_iff, e_idf, e_bub, e_fa, e_fb;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit hitf(input int rs, input int re, input int rd, input int we);
      return re != 0 && we != 0 && rd != 0 && rs == rd;
   endfunction

   function automatic int sel(input int rs, input int re);
      if (hitf(rs, re, ex_rd, ex_rf_we) && !ex_is_load) return 1;
      if (hitf(rs, re, mem_rd, mem_rf_we)) return 2;
      return 0;
   endfunction

   task automatic model_check();
      bit on, br, lu;
      on    = (rst_n == 1'b0);
      e_frz = on && dmem_req && !dmem_ack;
      br    = on && !e_frz && ex_br_taken;
      lu    = on && !e_frz && !br && ex_is_load &&
              (hitf(id_rs1, id_rs1_re, ex_rd, ex_rf_we) || hitf(id_rs2, id_rs2_re, ex_rd, ex_rf_we));
      e_pc  = e_frz || lu;
      e_idf = br || lu;
      chk("pc_stall", 32'(pc_stall), 32'(e_pc));
      chk("if_id_stall", 32'(if_id_stall), 32'(e_pc));
      chk("if_id_flush", 32'(if_id_flush), 32'(br));
      chk("id_ex_stall", 32'(id_ex_stall), 32'(e_frz));
      chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
      chk("ex_mem_stall", 32'(ex_mem_stall), 32'(e_frz));
      chk("mem_wb_bubble", 32'(mem_wb_bubble), 32'(e_frz));
      chk("fwd_a", 32'(fwd_a), m_fa);
      chk("fwd_b", 32'(fwd_b), m_fb);
      chk("stall_cnt", 32'(stall_cnt), m_scnt);
      chk("mem_timeout", 32'(mem_timeout), m_to);
   endtask

   task automatic model_update();
      if (rst_n) begin
         m_fa = 0; m_fb = 0; m_scnt = 0; m_to = 0; m_run = 0;
      end else begin
         m_run = e_frz ? m_run + 1 : 0;
         // The flag rises at the end of the (MT+1)-th consecutive frozen cycle
         if (m_run > MT) m_to = 1;
         if (e_pc && m_scnt < (1 << CW) - 1) m_scnt++;
         if (!e_frz) begin
            if (e_idf) begin
               m_fa = 0; m_fb = 0;
            end else begin
               m_fa = sel(id_rs1, id_rs1_re);
               m_fb = sel(id_rs2, id_rs2_re);
            end
         end
      end
   endtask

   task automatic cyc_begin();
      #4;
      model_check();
   endtask

   task automatic cyc_end();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rst_n = 1'b0;
      id_rs1 = '0; id_rs2 = '0; id_rs1_re = 0; id_rs2_re = 0;
      ex_rd = '0; ex_rf_we = 0; ex_is_load = 0; mem_rd = '0; mem_rf_we = 0;
      ex_br_taken = 0; dmem_req = 0; dmem_ack = 0;
   endtask

   task automatic drive(input vec_t v);
      rst_n = 1'b0;
      id_rs1 = 5'(v.rs1); id_rs1_re = 1'(v.re1); id_rs2 = 5'(v.rs2); id_rs2_re = 1'(v.re2);
      ex_rd = 5'(v.ex_rd); ex_rf_we = 1'(v.ex_we); ex_is_load = 1'(v.ex_ld);
      mem_rd = 5'(v.mem_rd); mem_rf_we = 1'(v.mem_we);
      ex_br_taken = 1'(v.br); dmem_req = 1'(v.req); dmem_ack = 1'(v.ack);
   endtask

   task automatic do_reset();
      set_idle();
      rst_n = 1'b1;
      cyc_begin();
      cyc_end();
      rst_n = 1'b0;
   endtask

   initial begin
      //          rs1 re rs2 re exrd we ld mrd we br rq ak | pc iff idf bub fa fb
      tbl[0]  = '{5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0};
      tbl[1]  = '{5, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0};
      tbl[2]  = '{0, 0, 3, 1, 3, 1, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1};
      tbl[3]  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
      tbl[4]  = '{5, 1, 5, 1, 5, 1, 1, 0, 0, 1, 0, 0,  0, 1, 1, 0, 0, 0};
      tbl[5]  = '{7, 1, 7, 1, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 2, 2};
      tbl[6]  = '{5, 0, 0, 0, 5, 1, 0, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
      tbl[7]  = '{9, 1, 0, 0, 9, 0, 0, 9, 1, 0, 0, 0,  0, 0, 0, 0, 2, 0};
      tbl[8]  = '{4, 1, 0, 0, 4, 1, 0, 0, 0, 1, 1, 0,  1, 0, 0, 1, 0, 0};
      tbl[9]  = '{6, 1, 0, 0, 6, 1, 1, 0, 0, 0, 1, 1,  1, 0, 1, 0, 0, 0};
      tbl[10] = '{8, 1, 0, 0, 8, 1, 0, 8, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0};

      m_fa = 0; m_fb = 0; m_scnt = 0; m_to = 0; m_run = 0;
      set_idle();
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset held with a pending memory request: every control stays low
      for (int k = 0; k < 2; k++) begin
         set_idle();
         rst_n = 1'b1; dmem_req = 1'b1;
         cyc_begin();
         chk("rst_pc_stall", 32'(pc_stall), 0);
         chk("rst_bubble", 32'(mem_wb_bubble), 0);
         chk("rst_stall_cnt", 32'(stall_cnt), 0);
         chk("rst_fwd_a", 32'(fwd_a), 0);
         cyc_end();
      end

      // Vector table: one cycle of stimulus, then one idle cycle for the fwd selects
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i]);
         cyc_begin();
         chk($sformatf("v%0d_pc_stall", i), 32'(pc_stall), tbl[i].e_pc);
         chk($sformatf("v%0d_if_id_flush", i), 32'(if_id_flush), tbl[i].e_iff);
         chk($sformatf("v%0d_id_ex_flush", i), 32'(id_ex_flush), tbl[i].e_idf);
         chk($sformatf("v%0d_bubble", i), 32'(mem_wb_bubble), tbl[i].e_bub);
         cyc_end();
         set_idle();
         cyc_begin();
         chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), tbl[i].e_fa);
         chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), tbl[i].e_fb);
         if (i == 0) chk("lu_stall_cnt", 32'(stall_cnt), 1);
         cyc_end();
      end

      // Memory wait: four frozen cycles with a pending branch, then release
      do_reset();
      set_idle();
      id_rs1 = 5'd2; id_rs1_re = 1; ex_rd = 5'd2; ex_rf_we = 1;
      cyc_begin();
      cyc_end();
      ex_rd = 5'd9; ex_br_taken = 1; dmem_req = 1;
      for (int k = 0; k < 4; k++) begin
         cyc_begin();
         chk("wait_pc_stall", 32'(pc_stall), 1);
         chk("wait_no_flush", 32'(if_id_flush), 0);
         chk("wait_fwd_hold", 32'(fwd_a), 1);
         cyc_end();
      end
      dmem_ack = 1;
      cyc_begin();
      chk("rel_if_id_flush", 32'(if_id_flush), 1);
      chk("rel_pc_stall", 32'(pc_stall), 0);
      chk("rel_stall_cnt", 32'(stall_cnt), 4);
      chk("rel_timeout", 32'(mem_timeout), 0);
      cyc_end();
      set_idle();
      cyc_begin();
      chk("rel_fwd_flushed", 32'(fwd_a), 0);
      cyc_end();

      // Timeout: sticky flag, stall counter saturation, reset mid-wait
      do_reset();
      set_idle();
      dmem_req = 1;
      for (int k = 0; k < 20; k++) begin
         cyc_begin();
         if (k < 6) chk($sformatf("to_c%0d", k), 32'(mem_timeout), (k >= 5) ? 1 : 0);
         cyc_end();
      end
      cyc_begin();
      chk("sat_stall_cnt", 32'(stall_cnt), 15);
      cyc_end();
      dmem_ack = 1;
      cyc_begin();
      chk("to_after_ack", 32'(mem_timeout), 1);
      cyc_end();
      set_idle();
      dmem_req = 1;
      cyc_begin();
      cyc_end();
      rst_n = 1;
      cyc_begin();
      chk("rst_mid_wait_pc", 32'(pc_stall), 0);
      cyc_end();
      rst_n = 0;
      dmem_req = 0;
      cyc_begin();
      chk("to_cleared", 32'(mem_timeout), 0);
      chk("cnt_cleared", 32'(stall_cnt), 0);
      cyc_end();

      // Randomized traffic checked cycle by cycle against the model
      for (int n = 0; n < 600; n++) begin
         rst_n       = ($urandom_range(0, 39) == 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_rs1_re   = 1'($urandom_range(0, 1));
         id_rs2_re   = 1'($urandom_range(0, 1));
         ex_rd       = 5'($urandom_range(0, 3));
         ex_rf_we    = 1'($urandom_range(0, 1));
         ex_is_load  = 1'($urandom_range(0, 1));
         mem_rd      = 5'($urandom_range(0, 3));
         mem_rf_we   = 1'($urandom_range(0, 1));
         ex_br_taken = ($urandom_range(0, 4) == 0);
         dmem_req    = ($urandom_range(0, 2) == 0) || (n % 100 > 90);
         dmem_ack    = ($urandom_range(0, 1) == 0) && (n % 100 <= 90);
         cyc_begin();
         cyc_end();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
